// File: rtl/bx_proc_sequencer_if.sv
// Memory-side bus of the BX sequencer: paged reads of the two input BRAMs,
// the read-data-valid strobe to the datapath and the output BRAM write port.
interface bx_proc_sequencer_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  mem1_enb;
  logic [ADDR_WIDTH-1:0] mem1_readaddr;
  logic                  mem2_enb;
  logic [ADDR_WIDTH-1:0] mem2_readaddr;
  logic                  rd_valid;
  logic                  memout_ena;
  logic                  memout_wea;
  logic [ADDR_WIDTH-1:0] memout_writeaddr;

  // Sequencer side: drives every memory control signal.
  modport master (
    output mem1_enb, mem1_readaddr, mem2_enb, mem2_readaddr,
    output rd_valid, memout_ena, memout_wea, memout_writeaddr
  );

  // Memory/datapath side: consumes the control signals.
  modport slave (
    input mem1_enb, mem1_readaddr, mem2_enb, mem2_readaddr,
    input rd_valid, memout_ena, memout_wea, memout_writeaddr
  );
endinterface

// File: rtl/bx_proc_sequencer.sv
// Per-BX controller: on a BX change it reads N entries from the current page of
// both input BRAMs, tracks each read through a fixed-latency valid/address pipe
// and commits the matching output BRAM writes, then reports done/bx_out.
// A BX arriving mid-pass truncates the reads and is queued as one pending start.
// The drain check assumes RD_LATENCY >= 1 and PROC_LATENCY >= 1.
module bx_proc_sequencer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int RD_LATENCY   = 2,
  parameter int PROC_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en_proc,
  input  logic [1:0]            i_bx_in,
  input  logic [ADDR_WIDTH-1:0] i_nevt1,
  input  logic [ADDR_WIDTH-1:0] i_nevt2,
  bx_proc_sequencer_if.master   bus,
  output logic [1:0]            o_bx_out,
  output logic                  o_done,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int DEPTH = RD_LATENCY + PROC_LATENCY;
  localparam int unsigned ENTRIES_I = 32'd1 << (ADDR_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ENTRIES = ENTRIES_I[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] ZERO_CNT = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_CNT  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Entries to process: the smaller count of the two memories, at most one page.
  function automatic logic [ADDR_WIDTH-1:0] calc_cnt(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [ADDR_WIDTH-1:0] b
  );
    logic [ADDR_WIDTH-1:0] m;
    m = (a < b) ? a : b;
    if (m > ENTRIES) begin
      m = ENTRIES;
    end else begin
      m = m;
    end
    return m;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_bx_q;
  logic [1:0]            r_bx, w_bx_nxt;
  logic                  r_page, w_page_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx_nxt;
  logic                  r_pend_v, w_pend_v_nxt;
  logic [1:0]            r_pend_bx, w_pend_bx_nxt;
  logic [ADDR_WIDTH-1:0] r_pend_cnt, w_pend_cnt_nxt;
  logic                  r_overrun, w_overrun_nxt;
  logic                  r_enb, w_enb_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
  logic                  r_done, w_done_nxt;
  logic [1:0]            r_bx_out, w_bx_out_nxt;
  logic                  r_busy;
  logic [DEPTH-1:0]      r_pipe_v;
  logic [ADDR_WIDTH-1:0] r_pipe_a [DEPTH];

  logic                  w_newbx;
  logic [ADDR_WIDTH-1:0] w_cnt_live;
  logic [ADDR_WIDTH-1:0] w_idx_inc;
  logic                  w_drain_empty;
  logic                  w_launch;
  logic [1:0]            w_launch_bx;
  logic [ADDR_WIDTH-1:0] w_launch_cnt;

  assign w_newbx       = (i_bx_in != r_bx_q);
  assign w_cnt_live    = calc_cnt(i_nevt1, i_nevt2);
  assign w_idx_inc     = r_idx + ONE_CNT;
  // The last stage is the write happening this cycle; nothing younger may remain.
  assign w_drain_empty = ~|r_pipe_v[DEPTH-2:0];

  // Next-state, pending-start bookkeeping and next values of the registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_bx_nxt       = r_bx;
    w_page_nxt     = r_page;
    w_cnt_nxt      = r_cnt;
    w_idx_nxt      = r_idx;
    w_pend_v_nxt   = r_pend_v;
    w_pend_bx_nxt  = r_pend_bx;
    w_pend_cnt_nxt = r_pend_cnt;
    w_overrun_nxt  = r_overrun | (w_newbx & (r_state != S_IDLE));
    w_enb_nxt      = 1'b0;
    w_done_nxt     = 1'b0;
    w_bx_out_nxt   = r_bx_out;
    w_launch       = 1'b0;
    w_launch_bx    = i_bx_in;
    w_launch_cnt   = w_cnt_live;

    // A BX seen while busy is remembered (latest wins) for after DONE.
    if (w_newbx && (r_state != S_IDLE) && i_en_proc) begin
      w_pend_v_nxt   = 1'b1;
      w_pend_bx_nxt  = i_bx_in;
      w_pend_cnt_nxt = w_cnt_live;
    end else begin
      w_pend_v_nxt   = w_pend_v_nxt;
    end

    case (r_state)
      S_IDLE: begin
        if (w_newbx && i_en_proc) begin
          w_launch = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_newbx) begin
          w_state_nxt = S_DRAIN;
        end else if (w_idx_inc < r_cnt) begin
          w_idx_nxt = w_idx_inc;
          w_enb_nxt = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drain_empty) begin
          w_state_nxt  = S_DONE;
          w_done_nxt   = 1'b1;
          w_bx_out_nxt = r_bx;
        end else begin
          w_state_nxt  = S_DRAIN;
        end
      end
      S_DONE: begin
        w_pend_v_nxt = 1'b0;
        if (w_newbx && i_en_proc) begin
          w_launch = 1'b1;
        end else if (r_pend_v) begin
          w_launch     = 1'b1;
          w_launch_bx  = r_pend_bx;
          w_launch_cnt = r_pend_cnt;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Starting a pass: latch BX, page and count, issue idx 0 unless empty.
    if (w_launch) begin
      w_bx_nxt    = w_launch_bx;
      w_page_nxt  = w_launch_bx[0];
      w_cnt_nxt   = w_launch_cnt;
      w_idx_nxt   = ZERO_CNT;
      w_enb_nxt   = (w_launch_cnt != ZERO_CNT);
      w_state_nxt = (w_launch_cnt != ZERO_CNT) ? S_READ : S_DRAIN;
    end else begin
      w_bx_nxt    = w_bx_nxt;
    end

    w_rd_addr_nxt = {w_page_nxt, w_idx_nxt[ADDR_WIDTH-2:0]};
  end

  // State, control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bx_q     <= i_bx_in;
      r_bx       <= 2'd0;
      r_page     <= 1'b0;
      r_cnt      <= ZERO_CNT;
      r_idx      <= ZERO_CNT;
      r_pend_v   <= 1'b0;
      r_pend_bx  <= 2'd0;
      r_pend_cnt <= ZERO_CNT;
      r_overrun  <= 1'b0;
      r_enb      <= 1'b0;
      r_rd_addr  <= ZERO_CNT;
      r_done     <= 1'b0;
      r_bx_out   <= 2'd0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bx_q     <= i_bx_in;
      r_bx       <= w_bx_nxt;
      r_page     <= w_page_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_pend_v   <= w_pend_v_nxt;
      r_pend_bx  <= w_pend_bx_nxt;
      r_pend_cnt <= w_pend_cnt_nxt;
      r_overrun  <= w_overrun_nxt;
      r_enb      <= w_enb_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_done     <= w_done_nxt;
      r_bx_out   <= w_bx_out_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Valid/address delay line from read issue to read-data-valid and output write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_v <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe_a[i] <= ZERO_CNT;
      end
    end else begin
      r_pipe_v    <= {r_pipe_v[DEPTH-2:0], r_enb};
      r_pipe_a[0] <= r_rd_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe_a[i] <= r_pipe_a[i-1];
      end
    end
  end

  assign bus.mem1_enb         = r_enb;
  assign bus.mem1_readaddr    = r_rd_addr;
  assign bus.mem2_enb         = r_enb;
  assign bus.mem2_readaddr    = r_rd_addr;
  assign bus.rd_valid         = r_pipe_v[RD_LATENCY-1];
  assign bus.memout_ena       = r_pipe_v[DEPTH-1];
  assign bus.memout_wea       = r_pipe_v[DEPTH-1];
  assign bus.memout_writeaddr = r_pipe_a[DEPTH-1];

  assign o_bx_out  = r_bx_out;
  assign o_done    = r_done;
  assign o_busy    = r_busy;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_bx_proc_sequencer.sv
// Directed bench for bx_proc_sequencer with hand-computed cycle schedules
// (RD_LATENCY=2, PROC_LATENCY=1, 16 entries per page).
module tb_bx_proc_sequencer;
  logic       clk;
  logic       reset;
  logic       en_proc;
  logic [1:0] bx_in;
  logic [4:0] nevt1;
  logic [4:0] nevt2;
  logic [1:0] bx_out;
  logic       done;
  logic       busy;
  logic       overrun;
  int         checks;
  int         errors;

  bx_proc_sequencer_if #(.ADDR_WIDTH(5)) bus ();

  bx_proc_sequencer #(.ADDR_WIDTH(5), .RD_LATENCY(2), .PROC_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_en_proc (en_proc),
    .i_bx_in   (bx_in),
    .i_nevt1   (nevt1),
    .i_nevt2   (nevt2),
    .bus       (bus),
    .o_bx_out  (bx_out),
    .o_done    (done),
    .o_busy    (busy),
    .o_overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (cycle t+%0d): observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // Check both read ports and the write port against one expected schedule entry.
  task automatic chk_cycle(input int k, input logic e_enb, input logic [4:0] e_ra,
                           input logic e_rv, input logic e_we, input logic [4:0] e_wa,
                           input logic e_done, input logic [1:0] e_bx, input logic e_busy);
    chk("mem1_enb", k, 32'(bus.mem1_enb), 32'(e_enb));
    chk("mem2_enb", k, 32'(bus.mem2_enb), 32'(e_enb));
    if (e_enb) begin
      chk("mem1_readaddr", k, 32'(bus.mem1_readaddr), 32'(e_ra));
      chk("mem2_readaddr", k, 32'(bus.mem2_readaddr), 32'(e_ra));
    end
    chk("rd_valid", k, 32'(bus.rd_valid), 32'(e_rv));
    chk("memout_wea", k, 32'(bus.memout_wea), 32'(e_we));
    chk("memout_ena", k, 32'(bus.memout_ena), 32'(e_we));
    if (e_we) begin
      chk("memout_writeaddr", k, 32'(bus.memout_writeaddr), 32'(e_wa));
    end
    chk("done", k, 32'(done), 32'(e_done));
    chk("bx_out", k, 32'(bx_out), 32'(e_bx));
    chk("busy", k, 32'(busy), 32'(e_busy));
  endtask

  // Uninterrupted pass started in the current cycle t: reads t+1..t+n,
  // rd_valid t+3..t+n+2, writes t+4..t+n+3, done t+n+4 (t+2 when n=0).
  task automatic check_pass(input logic [1:0] bx, input int n, input logic [1:0] prev_bx);
    int         done_k;
    logic       page;
    logic [4:0] ra;
    logic [4:0] wa;
    page   = bx[0];
    done_k = (n == 0) ? 2 : n + 4;
    for (int k = 1; k <= done_k + 1; k++) begin
      step();
      ra = {page, 4'(k - 1)};
      wa = {page, 4'(k - 4)};
      chk_cycle(k, (k <= n), ra, (k >= 3 && k <= n + 2), (k >= 4 && k <= n + 3), wa,
                (k == done_k), (k >= done_k) ? bx : prev_bx, (k <= done_k));
    end
  endtask

  initial begin
    logic [4:0] ra;
    logic [4:0] wa;
    logic [1:0] ebx;
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    en_proc = 1'b1;
    bx_in   = 2'd2;
    nevt1   = 5'd16;
    nevt2   = 5'd16;
    step();
    step();
    step();
    chk_cycle(0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    chk("overrun_reset", 0, 32'(overrun), 32'd0);
    chk("writeaddr_reset", 0, 32'(bus.memout_writeaddr), 32'd0);
    chk("readaddr_reset", 0, 32'(bus.mem1_readaddr), 32'd0);

    // Release: bx_in stayed at 2, so no pass may start.
    reset = 1'b0;
    step();
    step();
    chk("no_start_after_reset", 0, 32'(busy), 32'd0);
    chk("no_enb_after_reset", 0, 32'(bus.mem1_enb), 32'd0);

    // Steady state: bx 2->3, N=16 on page 1.
    bx_in = 2'd3;
    check_pass(2'd3, 16, 2'd0);
    chk("overrun_steady", 0, 32'(overrun), 32'd0);

    // Page select: bx 0, N=min(5,9)=5 on page 0.
    bx_in = 2'd0;
    nevt1 = 5'd5;
    nevt2 = 5'd9;
    check_pass(2'd0, 5, 2'd3);

    // Empty BX: nevt1=0.
    step();
    bx_in = 2'd1;
    nevt1 = 5'd0;
    nevt2 = 5'd7;
    check_pass(2'd1, 0, 2'd0);

    // Clamp: counts above one page are limited to 16 (covered by overrun below),
    // en_proc low across a BX change: nothing happens.
    en_proc = 1'b0;
    bx_in   = 2'd2;
    nevt1   = 5'd20;
    nevt2   = 5'd31;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_cycle(k, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0);
    end
    en_proc = 1'b1;
    step();
    chk("no_late_start", 0, 32'(busy), 32'd0);

    // Overrun: bx 2->3 (N=clamp(20,31)=16, page 1); bx 3->0 at t+10.
    // First pass truncated to 10 reads, done t+14; pending pass is the
    // DONE cycle's start: reads t+15..t+30 on page 0, done t+34.
    bx_in = 2'd3;
    for (int k = 1; k <= 35; k++) begin
      step();
      ra  = (k <= 10) ? {1'b1, 4'(k - 1)} : {1'b0, 4'(k - 15)};
      wa  = (k <= 13) ? {1'b1, 4'(k - 4)} : {1'b0, 4'(k - 18)};
      ebx = (k < 14) ? 2'd1 : ((k < 34) ? 2'd3 : 2'd0);
      chk_cycle(k, (k <= 10) || (k >= 15 && k <= 30), ra,
                (k >= 3 && k <= 12) || (k >= 17 && k <= 32),
                (k >= 4 && k <= 13) || (k >= 18 && k <= 33), wa,
                (k == 14) || (k == 34), ebx, (k <= 34));
      chk("overrun", k, 32'(overrun), 32'(k >= 11));
      if (k == 10) begin
        bx_in = 2'd0;
      end
    end

    // Reset at t+6 of a pass: everything zero at t+7, no writes afterwards.
    bx_in = 2'd1;
    nevt1 = 5'd16;
    nevt2 = 5'd16;
    for (int k = 1; k <= 6; k++) begin
      step();
    end
    chk("wea_before_reset", 6, 32'(bus.memout_wea), 32'd1);
    reset = 1'b1;
    step();
    chk_cycle(7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    chk("overrun_cleared", 7, 32'(overrun), 32'd0);
    reset = 1'b0;
    for (int k = 8; k <= 14; k++) begin
      step();
      chk_cycle(k, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
